// File: rtl/pcie_fbuf_mq.sv
// pcie_fbuf_mq: per-channel free-buffer descriptor FIFOs sharing one partitioned simple-dual-port RAM.
// Optional build macro FBUF_RR_ARB_EN: reads pick the channel round-robin instead of using FBUF_RD_CH.
module pcie_fbuf_mq #(
   parameter int  DW           = 96,
   parameter int  NCH          = 4,
   parameter int  AW           = 9,
   parameter int  AFULL_MARGIN = 4,
   localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  PCIE_CLK,
   input  logic                  PCIE_RST,
   output logic [NCH-1:0]        FBUF_WR_RDY,
   input  logic                  FBUF_WR_REQ,
   input  logic [CW-1:0]         FBUF_WR_CH,
   input  logic [DW-1:0]         FBUF_WR_DATA,
   output logic [NCH*(AW+1)-1:0] FBUF_DCNT,
   input  logic [NCH-1:0]        FBUF_FLUSH,
   output logic [NCH-1:0]        FBUF_RD_RDY,
   input  logic                  FBUF_RD_REQ,
   input  logic [CW-1:0]         FBUF_RD_CH,
   output logic                  FBUF_RD_VLD,
   output logic [CW-1:0]         FBUF_RD_DCH,
   output logic [DW-1:0]         FBUF_RD_DATA,
   output logic                  FBUF_ERR
);
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] LP_WR_TH = (AW+1)'(DEPTH - AFULL_MARGIN - 1);

   logic                  r_wr_req_p0, r_rd_req_p0;
   logic [CW-1:0]         r_wr_ch_p0, r_rd_ch_p0;
   logic [DW-1:0]         r_wr_data_p0;
   logic [AW:0]           r_wptr [NCH];
   logic [AW:0]           r_rptr [NCH];
   logic [AW:0]           w_cnt  [NCH];
   logic [DW-1:0]         r_mem  [NCH*DEPTH];
   logic                  r_vld_p1;
   logic [CW-1:0]         r_dch_p1;
   logic [DW-1:0]         r_data_p1;
   logic                  r_err;
   logic [NCH-1:0]        r_wr_rdy, r_rd_rdy;
   logic [NCH*(AW+1)-1:0] r_dcnt;
   logic                  r_rd_vld;
   logic [CW-1:0]         r_rd_dch;
   logic [DW-1:0]         r_rd_data;
   logic                  w_wr_ok, w_wr_rej, w_rd_hit, w_rd_ok, w_rd_rej;
   logic [CW-1:0]         w_rd_sel;
`ifdef FBUF_RR_ARB_EN
   logic [CW-1:0]         r_last;
`endif

   // Stage p0: register the requests from the register block
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         r_wr_req_p0 <= 1'b0;
         r_rd_req_p0 <= 1'b0;
         r_wr_ch_p0  <= '0;
         r_rd_ch_p0  <= '0;
      end else begin
         r_wr_req_p0 <= FBUF_WR_REQ;
         r_rd_req_p0 <= FBUF_RD_REQ;
         r_wr_ch_p0  <= FBUF_WR_CH;
         r_rd_ch_p0  <= FBUF_RD_CH;
      end
   end

   always_ff @(posedge PCIE_CLK) begin
      r_wr_data_p0 <= FBUF_WR_DATA;
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w_cnt[c] = r_wptr[c] - r_rptr[c];
      end
   end

   // The count MSB is set only when a channel holds exactly DEPTH entries
   always_comb begin
      w_rd_hit = r_rd_req_p0;
      w_rd_sel = r_rd_ch_p0;
`ifdef FBUF_RR_ARB_EN
      w_rd_hit = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         if (!w_rd_hit && r_rd_req_p0 && r_rd_rdy[CW'((int'(r_last) + i) % NCH)]) begin
            w_rd_hit = 1'b1;
            w_rd_sel = CW'((int'(r_last) + i) % NCH);
         end
      end
`endif
      w_wr_ok  = r_wr_req_p0 && !w_cnt[r_wr_ch_p0][AW];
      w_wr_rej = r_wr_req_p0 &&  w_cnt[r_wr_ch_p0][AW];
      w_rd_ok  = w_rd_hit && (w_cnt[w_rd_sel] != '0);
      w_rd_rej = r_rd_req_p0 && !w_rd_ok;
   end

   // Stage p1: pointer update, error flag, RAM access
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         for (int c = 0; c < NCH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
         end
         r_err    <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_dch_p1 <= '0;
`ifdef FBUF_RR_ARB_EN
         r_last   <= CW'(NCH - 1);
`endif
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (FBUF_FLUSH[c]) begin
               r_wptr[c] <= '0;
               r_rptr[c] <= '0;
            end else begin
               if (w_wr_ok && (r_wr_ch_p0 == CW'(c))) r_wptr[c] <= r_wptr[c] + (AW+1)'(1);
               if (w_rd_ok && (w_rd_sel == CW'(c)))   r_rptr[c] <= r_rptr[c] + (AW+1)'(1);
            end
         end
         if (w_wr_rej || w_rd_rej) r_err <= 1'b1;
         r_vld_p1 <= w_rd_ok;
         r_dch_p1 <= w_rd_sel;
`ifdef FBUF_RR_ARB_EN
         if (w_rd_ok) r_last <= w_rd_sel;
`endif
      end
   end

   always_ff @(posedge PCIE_CLK) begin
      if (w_wr_ok) r_mem[{r_wr_ch_p0, r_wptr[r_wr_ch_p0][AW-1:0]}] <= r_wr_data_p0;
      if (w_rd_ok) r_data_p1 <= r_mem[{w_rd_sel, r_rptr[w_rd_sel][AW-1:0]}];
   end

   // Stage p2: registered flags, counts and read return
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         r_wr_rdy  <= '1;
         r_rd_rdy  <= '0;
         r_dcnt    <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_dch  <= '0;
         r_rd_data <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            r_wr_rdy[c]                <= (w_cnt[c] <= LP_WR_TH);
            r_rd_rdy[c]                <= (w_cnt[c] != '0);
            r_dcnt[c*(AW+1) +: (AW+1)] <= w_cnt[c];
         end
         r_rd_vld  <= r_vld_p1;
         r_rd_dch  <= r_dch_p1;
         r_rd_data <= r_data_p1;
      end
   end

   assign FBUF_WR_RDY  = r_wr_rdy;
   assign FBUF_RD_RDY  = r_rd_rdy;
   assign FBUF_DCNT    = r_dcnt;
   assign FBUF_RD_VLD  = r_rd_vld;
   assign FBUF_RD_DCH  = r_rd_dch;
   assign FBUF_RD_DATA = r_rd_data;
   assign FBUF_ERR     = r_err;
endmodule

// File: tb/tb_pcie_fbuf_mq.sv
// tb_pcie_fbuf_mq: directed and randomized bench with a queue-based reference model for pcie_fbuf_mq.
module tb_pcie_fbuf_mq;
   localparam int DW = 96, NCH = 4, AW = 9, AFM = 4, CW = 2, DEPTH = 512, CNTW = AW + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NCH-1:0]       wr_rdy, rd_rdy, flush;
   logic                 wr_req, rd_req, rd_vld, err;
   logic [CW-1:0]        wr_ch, rd_ch, rd_dch;
   logic [DW-1:0]        wr_data, rd_data;
   logic [NCH*CNTW-1:0]  dcnt;

   always #5 clk = ~clk;

   pcie_fbuf_mq #(.DW(DW), .NCH(NCH), .AW(AW), .AFULL_MARGIN(AFM)) dut (
      .PCIE_CLK(clk), .PCIE_RST(rst),
      .FBUF_WR_RDY(wr_rdy), .FBUF_WR_REQ(wr_req), .FBUF_WR_CH(wr_ch), .FBUF_WR_DATA(wr_data),
      .FBUF_DCNT(dcnt), .FBUF_FLUSH(flush), .FBUF_RD_RDY(rd_rdy),
      .FBUF_RD_REQ(rd_req), .FBUF_RD_CH(rd_ch), .FBUF_RD_VLD(rd_vld),
      .FBUF_RD_DCH(rd_dch), .FBUF_RD_DATA(rd_data), .FBUF_ERR(err));

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: one queue per channel, plus the request held in the input register stage
   logic [DW-1:0] mq [NCH][$];
   bit            pw_req, pr_req, rs_vld, e_vld, e_err, m_rd_ok, m_wr_ok;
   int            pw_ch, pr_ch, rs_ch, e_dch, m_last, m_rch;
   logic [DW-1:0] pw_data, rs_data, e_data;
   int            e_cnt [NCH];
   bit            e_rdrdy [NCH], e_wrrdy [NCH], prev_rdy [NCH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            e_cnt[c] = 0; e_rdrdy[c] = 1'b0; e_wrrdy[c] = 1'b1;
         end
         pw_req = 1'b0; pr_req = 1'b0; rs_vld = 1'b0;
         e_vld = 1'b0; e_dch = 0; e_data = '0; e_err = 1'b0; m_last = NCH - 1;
      end else begin
         for (int c = 0; c < NCH; c++) prev_rdy[c] = e_rdrdy[c];
         e_vld = rs_vld; e_dch = rs_ch; e_data = rs_data;
         for (int c = 0; c < NCH; c++) begin
            e_cnt[c]   = mq[c].size();
            e_rdrdy[c] = (mq[c].size() != 0);
            e_wrrdy[c] = (mq[c].size() <= DEPTH - AFM - 1);
         end
         m_rch = pr_ch;
`ifdef FBUF_RR_ARB_EN
         m_rch = -1;
         for (int i = 1; i <= NCH; i++)
            if (m_rch < 0 && prev_rdy[(m_last + i) % NCH]) m_rch = (m_last + i) % NCH;
`endif
         m_rd_ok = pr_req && (m_rch >= 0) && (mq[m_rch].size() != 0);
         m_wr_ok = pw_req && (mq[pw_ch].size() != DEPTH);
         if ((pr_req && !m_rd_ok) || (pw_req && !m_wr_ok)) e_err = 1'b1;
         rs_vld = 1'b0;
         if (m_rd_ok) begin
            rs_vld = 1'b1; rs_ch = m_rch; rs_data = mq[m_rch].pop_front(); m_last = m_rch;
         end
         if (m_wr_ok) mq[pw_ch].push_back(pw_data);
         for (int c = 0; c < NCH; c++) if (flush[c]) mq[c].delete();
         pw_req = wr_req; pw_ch = int'(wr_ch); pw_data = wr_data;
         pr_req = rd_req; pr_ch = int'(rd_ch);
      end
   end

   always @(posedge clk) cyc++;

   // Every-cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NCH-1:0]      v_wr, v_rd;
         logic [NCH*CNTW-1:0] v_cnt;
         for (int c = 0; c < NCH; c++) begin
            v_wr[c] = e_wrrdy[c];
            v_rd[c] = e_rdrdy[c];
            v_cnt[c*CNTW +: CNTW] = CNTW'(e_cnt[c]);
         end
         chk("WR_RDY", 128'(wr_rdy), 128'(v_wr));
         chk("RD_RDY", 128'(rd_rdy), 128'(v_rd));
         chk("DCNT", 128'(dcnt), 128'(v_cnt));
         chk("ERR", 128'(err), 128'(e_err));
         chk("RD_VLD", 128'(rd_vld), 128'(e_vld));
         if (e_vld) begin
            chk("RD_DCH", 128'(rd_dch), 128'(e_dch));
            chk("RD_DATA", 128'(rd_data), 128'(e_data));
         end
      end
   end

   logic [DW-1:0] resp_d [$];
   int            resp_c [$], resp_ch [$], req_c [$];

   always @(negedge clk) begin
      if (!rst && rd_vld) begin
         resp_d.push_back(rd_data); resp_c.push_back(cyc); resp_ch.push_back(int'(rd_dch));
      end
   end

   task automatic clr_resp();
      resp_d.delete(); resp_c.delete(); resp_ch.delete(); req_c.delete();
   endtask

   task automatic drive(input bit wr, input int wch, input logic [DW-1:0] wd,
                        input bit rd, input int rch, input logic [NCH-1:0] fl);
      wr_req = wr; wr_ch = CW'(wch); wr_data = wd;
      rd_req = rd; rd_ch = CW'(rch); flush = fl;
      if (rd) req_c.push_back(cyc);
      @(posedge clk); #2;
      wr_req = 1'b0; rd_req = 1'b0; flush = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; flush = '0;
      clr_resp();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   function automatic int cnt_of(input int c);
      return int'(dcnt[c*CNTW +: CNTW]);
   endfunction

   int last_rd;
   bit w, r;
   int wc, rc;
   logic [NCH-1:0] fl;

   initial begin
      wr_req = 1'b0; rd_req = 1'b0; flush = '0; wr_ch = '0; rd_ch = '0; wr_data = '0;
      #1 rst = 1'b1;
      chk_en = 1'b1;
      idle(2);
      chk("rst_WR_RDY", 128'(wr_rdy), 128'(4'hF));
      chk("rst_RD_RDY", 128'(rd_rdy), 128'(0));
      chk("rst_DCNT", 128'(dcnt), 128'(0));
      chk("rst_RD_VLD", 128'(rd_vld), 128'(0));
      chk("rst_ERR", 128'(err), 128'(0));
      #2 rst = 1'b0;
      idle(1);

      // Five descriptors through channel 2
      clr_resp();
      for (int i = 1; i <= 5; i++) drive(1'b1, 2, DW'(i), 1'b0, 0, '0);
      idle(3);
      chk("ch2_dcnt", 128'(cnt_of(2)), 128'(5));
      chk("ch2_rdrdy", 128'(rd_rdy), 128'(4'b0100));
      for (int i = 0; i < 5; i++) drive(1'b0, 0, '0, 1'b1, 2, '0);
      idle(4);
      chk("ch2_nresp", 128'(resp_d.size()), 128'(5));
      if (resp_d.size() == 5)
         for (int i = 0; i < 5; i++) begin
            chk("ch2_data", 128'(resp_d[i]), 128'(i + 1));
            chk("ch2_lat", 128'(resp_c[i] - req_c[i]), 128'(3));
            chk("ch2_dch", 128'(resp_ch[i]), 128'(2));
         end

      // Fill channel 0 to the brim and overflow it
      do_reset();
      for (int i = 0; i < 507; i++) drive(1'b1, 0, DW'(i + 'h100), 1'b0, 0, '0);
      idle(3);
      chk("fill507_wrrdy", 128'(wr_rdy[0]), 128'(1));
      drive(1'b1, 0, DW'(507 + 'h100), 1'b0, 0, '0);
      idle(3);
      chk("fill508_wrrdy", 128'(wr_rdy[0]), 128'(0));
      chk("fill508_dcnt", 128'(cnt_of(0)), 128'(508));
      for (int i = 508; i < 512; i++) drive(1'b1, 0, DW'(i + 'h100), 1'b0, 0, '0);
      idle(3);
      chk("fill512_dcnt", 128'(cnt_of(0)), 128'(512));
      chk("fill512_err", 128'(err), 128'(0));
      drive(1'b1, 0, DW'('hDEAD), 1'b0, 0, '0);
      idle(3);
      chk("ovf_err", 128'(err), 128'(1));
      chk("ovf_dcnt", 128'(cnt_of(0)), 128'(512));
      chk("ovf_others", 128'(dcnt[NCH*CNTW-1:CNTW]), 128'(0));
      chk("ovf_wrrdy", 128'(wr_rdy), 128'(4'b1110));
      clr_resp();
      drive(1'b0, 0, '0, 1'b1, 0, '0);
      idle(4);
      chk("ovf_first", 128'(resp_d.size() == 1 ? resp_d[0] : '1), 128'('h100));

      // Reset while a read is in flight
      drive(1'b0, 0, '0, 1'b1, 0, '0);
      rst = 1'b1;
      clr_resp();
      idle(2);
      rst = 1'b0;
      idle(4);
      chk("rst_inflight", 128'(resp_d.size()), 128'(0));
      chk("rst_dcnt", 128'(dcnt), 128'(0));

      // Read of an empty channel
      drive(1'b0, 0, '0, 1'b1, 1, '0);
      idle(4);
      chk("empty_err", 128'(err), 128'(1));
      chk("empty_novld", 128'(resp_d.size()), 128'(0));
      chk("empty_dcnt", 128'(cnt_of(1)), 128'(0));
      drive(1'b1, 1, DW'('h55), 1'b0, 0, '0);
      idle(3);
      drive(1'b0, 0, '0, 1'b1, 1, '0);
      idle(4);
      chk("empty_after", 128'(resp_d.size() == 1 ? resp_d[0] : '1), 128'('h55));

      // Steady write+read on channel 3 across pointer wrap
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, 3, {$urandom, $urandom, $urandom}, 1'b0, 0, '0);
      idle(3);
      for (int i = 0; i < 600; i++) drive(1'b1, 3, {$urandom, $urandom, $urandom}, 1'b1, 3, '0);
      idle(4);
      chk("wrap_dcnt", 128'(cnt_of(3)), 128'(10));
      chk("wrap_nresp", 128'(resp_d.size()), 128'(600));

      // Flush racing a write on channel 0
      do_reset();
      for (int i = 0; i < 7; i++) drive(1'b1, 0, DW'(i + 'h30), 1'b0, 0, '0);
      idle(3);
      drive(1'b1, 0, DW'('h77), 1'b0, 0, '0);
      drive(1'b0, 0, '0, 1'b0, 0, 4'b0001);
      idle(3);
      chk("flush_dcnt", 128'(cnt_of(0)), 128'(0));
      chk("flush_rdrdy", 128'(rd_rdy[0]), 128'(0));
      drive(1'b1, 0, DW'('hAA), 1'b0, 0, '0);
      idle(3);
      drive(1'b0, 0, '0, 1'b1, 0, '0);
      idle(4);
      chk("flush_aa", 128'(resp_d.size() == 1 ? resp_d[0] : '1), 128'('hAA));

`ifdef FBUF_RR_ARB_EN
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 0, DW'(i), 1'b0, 0, '0);
         drive(1'b1, 2, DW'(i), 1'b0, 0, '0);
         drive(1'b1, 3, DW'(i), 1'b0, 0, '0);
      end
      idle(3);
      for (int i = 0; i < 6; i++) begin drive(1'b0, 0, '0, 1'b1, 1, '0); idle(3); end
      idle(2);
      chk("rr_n", 128'(resp_ch.size()), 128'(6));
      if (resp_ch.size() == 6)
         for (int i = 0; i < 6; i++) chk("rr_dch", 128'(resp_ch[i]), 128'((i % 3 == 0) ? 0 : (i % 3) + 1));
`endif

      // Randomized traffic, honouring ready flags most of the time
      do_reset();
      last_rd = -1;
      for (int n = 0; n < 3000; n++) begin
         wc = int'($urandom_range(0, NCH - 1));
         rc = int'($urandom_range(0, NCH - 1));
         w  = ($urandom_range(0, 9) < 6) && (wr_rdy[wc] || $urandom_range(0, 15) == 0);
         r  = ($urandom_range(0, 1) == 1) && (rd_rdy[rc] || $urandom_range(0, 15) == 0);
         fl = '0;
         if ($urandom_range(0, 63) == 0) fl[$urandom_range(0, NCH - 1)] = 1'b1;
         if (last_rd >= 0) fl[last_rd] = 1'b0;
         drive(w, wc, {$urandom, $urandom, $urandom}, r, rc, fl);
         last_rd = r ? rc : -1;
         if (r && $urandom_range(0, 1) == 1) idle(1);
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
